// File: rtl/imem_arbiter_if.sv
// Bus bundle for imem_arbiter: fetch and LSU request/response channels,
// the single-port instruction memory port, and the conflict counter.
interface imem_arbiter_if #(
  parameter int ADDR_W = 20
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              if_err;
  logic              ls_req;
  logic [31:0]       ls_addr;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [31:0]       ls_rdata;
  logic              ls_err;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic [15:0]       conflict_cnt;

  modport slave (
    input  if_req, if_addr, ls_req, ls_addr, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output ls_gnt, ls_rvalid, ls_rdata, ls_err,
    output mem_req, mem_addr, conflict_cnt
  );

  modport master (
    output if_req, if_addr, ls_req, ls_addr, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
    input  mem_req, mem_addr, conflict_cnt
  );
endinterface

// File: rtl/imem_arbiter.sv
// Arbiter sharing one single-port instruction memory between fetch and LSU.
// Define IMEM_ARB_RR_EN for round-robin conflicts; default is LSU-wins priority.
module imem_arbiter #(
  parameter int ADDR_W = 20
) (
  input  logic           clk,
  input  logic           rst,
  imem_arbiter_if.slave  bus
);

  localparam logic [1:0] R_NONE = 2'd0;
  localparam logic [1:0] R_IF   = 2'd1;
  localparam logic [1:0] R_LS   = 2'd2;

  // Word-aligned and inside the 2**ADDR_W word window.
  function automatic logic addr_ok(input logic [31:0] a);
    addr_ok = (a[1:0] == 2'b00) && ((a >> (ADDR_W + 2)) == 32'd0);
  endfunction

  logic [1:0]  state_r;
  logic        err_r;
  logic [15:0] cnt_r;
  logic        conflict_s;
  logic        if_wins_s;
  logic        if_gnt_s;
  logic        ls_gnt_s;
  logic [31:0] win_addr_s;
  logic        win_ok_s;
  logic        mem_req_s;

`ifdef IMEM_ARB_RR_EN
  logic        last_if_r;
`endif

  // Arbitration and memory request, all combinational from the inputs.
  always_comb begin
    conflict_s = bus.if_req & bus.ls_req;
`ifdef IMEM_ARB_RR_EN
    if_wins_s  = bus.if_req & (~bus.ls_req | ~last_if_r);
`else
    if_wins_s  = bus.if_req & ~bus.ls_req;
`endif
    if (rst) begin
      if_gnt_s = 1'b0;
      ls_gnt_s = 1'b0;
    end else begin
      if_gnt_s = if_wins_s;
      ls_gnt_s = bus.ls_req & ~if_wins_s;
    end
    win_addr_s = if_gnt_s ? bus.if_addr : bus.ls_addr;
    win_ok_s   = addr_ok(win_addr_s);
    mem_req_s  = (if_gnt_s | ls_gnt_s) & win_ok_s;
    bus.if_gnt  = if_gnt_s;
    bus.ls_gnt  = ls_gnt_s;
    bus.mem_req = mem_req_s;
    if (mem_req_s) begin
      bus.mem_addr = win_addr_s[ADDR_W+1:2];
    end else begin
      bus.mem_addr = {ADDR_W{1'b0}};
    end
  end

  // Response state, error flag and saturating conflict counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= R_NONE;
      err_r   <= 1'b0;
      cnt_r   <= 16'd0;
    end else begin
      if (if_gnt_s) begin
        state_r <= R_IF;
      end else if (ls_gnt_s) begin
        state_r <= R_LS;
      end else begin
        state_r <= R_NONE;
      end
      err_r <= (if_gnt_s | ls_gnt_s) & ~win_ok_s;
      if (conflict_s && (cnt_r != 16'hFFFF)) begin
        cnt_r <= cnt_r + 16'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

`ifdef IMEM_ARB_RR_EN
  // Last-granted pointer; reset value lets fetch win the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_if_r <= 1'b0;
    end else if (if_gnt_s | ls_gnt_s) begin
      last_if_r <= if_gnt_s;
    end else begin
      last_if_r <= last_if_r;
    end
  end
`endif

  // Response outputs; data and error are zero whenever rvalid is low.
  always_comb begin
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = 32'd0;
    bus.if_err    = 1'b0;
    bus.ls_rvalid = 1'b0;
    bus.ls_rdata  = 32'd0;
    bus.ls_err    = 1'b0;
    case (state_r)
      R_IF: begin
        bus.if_rvalid = 1'b1;
        bus.if_err    = err_r;
        bus.if_rdata  = err_r ? 32'd0 : bus.mem_rdata;
      end
      R_LS: begin
        bus.ls_rvalid = 1'b1;
        bus.ls_err    = err_r;
        bus.ls_rdata  = err_r ? 32'd0 : bus.mem_rdata;
      end
      default: begin
        bus.if_rvalid = 1'b0;
        bus.ls_rvalid = 1'b0;
      end
    endcase
    bus.conflict_cnt = cnt_r;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: random and directed requests checked
// against a transaction-level model; a separate monitor checks responses.
module tb_imem_arbiter;

  localparam int ADDR_W = 20;
`ifdef IMEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef struct {
    int          due;
    bit          is_if;
    logic [31:0] data;
    bit          err;
  } resp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  resp_t sb[$];

  int    model_cnt = 0;
  bit    model_last_if = 1'b0;

  imem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  imem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] w);
    if (w == 32'd5) return 32'hDEADBEEF;
    return (w * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Memory: registered read data one cycle after mem_req.
  always @(posedge clk) begin
    if (bus.mem_req) bus.mem_rdata <= mem_word(32'(bus.mem_addr));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard whenever a response is due.
  always @(negedge clk) begin
    resp_t e;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      void'(sb.pop_front());
      chk("stale_resp", 32'd1, 32'd0);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("if_rvalid", bus.if_rvalid, e.is_if);
      chk("ls_rvalid", bus.ls_rvalid, !e.is_if);
      chk("if_rdata", bus.if_rdata, e.is_if ? e.data : 32'd0);
      chk("ls_rdata", bus.ls_rdata, e.is_if ? 32'd0 : e.data);
      chk("if_err", bus.if_err, e.is_if ? e.err : 1'b0);
      chk("ls_err", bus.ls_err, e.is_if ? 1'b0 : e.err);
    end else begin
      chk("idle_rvalid", {bus.if_rvalid, bus.ls_rvalid, bus.if_err, bus.ls_err}, 32'd0);
      chk("idle_rdata", bus.if_rdata | bus.ls_rdata, 32'd0);
    end
  end

  // One cycle of stimulus; returns winner (0 none, 1 fetch, 2 LSU).
  task automatic step(input bit ir, input logic [31:0] ia, input bit lr,
                      input logic [31:0] la, output int who);
    logic [31:0] a;
    bit          ok;
    resp_t       e;
    @(posedge clk);
    #1;
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.ls_req  = lr;
    bus.ls_addr = la;
    if (ir && lr) who = RR_EN ? (model_last_if ? 2 : 1) : 2;
    else if (ir)  who = 1;
    else if (lr)  who = 2;
    else          who = 0;
    if (RR_EN && who != 0) model_last_if = (who == 1);
    a  = (who == 1) ? ia : la;
    ok = (a % 4 == 0) && (longint'(a) < (longint'(1) << (ADDR_W + 2)));
    if (who != 0) begin
      e.due   = cyc + 1;
      e.is_if = (who == 1);
      e.err   = !ok;
      e.data  = ok ? mem_word(a / 4) : 32'd0;
      sb.push_back(e);
    end
    @(negedge clk);
    chk("if_gnt", bus.if_gnt, who == 1);
    chk("ls_gnt", bus.ls_gnt, who == 2);
    chk("mem_req", bus.mem_req, (who != 0) && ok);
    chk("mem_addr", bus.mem_addr, ((who != 0) && ok) ? a / 4 : 32'd0);
    chk("conflict_cnt", bus.conflict_cnt, model_cnt);
    if (ir && lr && model_cnt < 65535) model_cnt++;
  endtask

  // Assert reset from just after a falling edge, holding requests high.
  task automatic do_reset(input int cycles);
    #1;
    rst = 1'b1;
    sb.delete();
    model_cnt     = 0;
    model_last_if = 1'b0;
    bus.if_req  = 1'b1;
    bus.ls_req  = 1'b1;
    bus.if_addr = 32'h0;
    bus.ls_addr = 32'h4;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("rst_gnt", {bus.if_gnt, bus.ls_gnt}, 32'd0);
      chk("rst_mem_req", bus.mem_req, 1'b0);
      chk("rst_cnt", bus.conflict_cnt, 32'd0);
    end
    #1;
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return ($urandom_range(0, 255) << 2) | $urandom_range(1, 3);
    if (r == 1) return $urandom | 32'h0040_0000;
    if (r == 2) return ((32'd1 << ADDR_W) - 32'd1) << 2;
    return $urandom_range(0, 63) << 2;
  endfunction

  initial begin
    int          who;
    bit          ir, lr;
    logic [31:0] ia, la;
    bit          exp_if[4];

    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    bus.if_addr = 32'h0; bus.ls_addr = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_rvalid", {bus.if_rvalid, bus.ls_rvalid}, 32'd0);
    chk("reset_cnt", bus.conflict_cnt, 32'd0);
    do_reset(2);

    // Fetch of word 5 alone.
    step(1'b1, 32'h14, 1'b0, 32'h0, who);
    chk("dir_if_gnt", bus.if_gnt, 1'b1);
    chk("dir_mem_addr", bus.mem_addr, 32'd5);
    step(1'b0, 32'h0, 1'b0, 32'h0, who);

    // Invalid LSU addresses: misaligned and out of range.
    step(1'b0, 32'h0, 1'b1, 32'h6, who);
    chk("dir_mis_mem_req", bus.mem_req, 1'b0);
    step(1'b0, 32'h0, 1'b1, 32'h0040_0000, who);
    chk("dir_oor_mem_req", bus.mem_req, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, who);

    // Four conflict cycles straight after reset.
    do_reset(1);
    exp_if = RR_EN ? '{1'b1, 1'b0, 1'b1, 1'b0} : '{1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 32'h0, 1'b1, 32'h4, who);
      chk("conf_seq_if", bus.if_gnt, exp_if[k]);
    end
    step(1'b0, 32'h0, 1'b0, 32'h0, who);
    chk("conf_cnt4", bus.conflict_cnt, 32'd4);

    // Reset between a grant and its response drops the response.
    step(1'b1, 32'h8, 1'b0, 32'h0, who);
    do_reset(2);
    chk("post_rst_cnt", bus.conflict_cnt, 32'd0);
    step(1'b0, 32'h0, 1'b0, 32'h0, who);
    step(1'b0, 32'h0, 1'b0, 32'h0, who);

    // Random traffic; a losing requester holds its request.
    ir = 1'b0; lr = 1'b0; ia = 32'h0; la = 32'h0;
    for (int i = 0; i < 600; i++) begin
      if (!ir) begin
        ir = ($urandom_range(0, 99) < 60);
        ia = rand_addr();
      end
      if (!lr) begin
        lr = ($urandom_range(0, 99) < 50);
        la = rand_addr();
      end
      step(ir, ia, lr, la, who);
      if (who == 1) ir = 1'b0;
      if (who == 2) lr = 1'b0;
    end
    step(1'b0, 32'h0, 1'b0, 32'h0, who);
    step(1'b0, 32'h0, 1'b0, 32'h0, who);

    // Saturation of the conflict counter.
    do_reset(1);
    for (int i = 0; i < 65540; i++) begin
      step(1'b1, 32'h0, 1'b1, 32'h4, who);
    end
    step(1'b0, 32'h0, 1'b0, 32'h0, who);
    chk("conf_sat", bus.conflict_cnt, 32'h0000FFFF);
    step(1'b0, 32'h0, 1'b0, 32'h0, who);
    step(1'b0, 32'h0, 1'b0, 32'h0, who);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
